// File: rtl/dmi_pkg.sv
// Shared types for the DMI session arbiter: FSM states, response op codes and field positions.
package dmi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RSP,
    DLV,
    HOLD
  } state_t;

  localparam logic [1:0] DMI_OP_FAILED = 2'b10;

  localparam int RSP_OP_LSB   = 0;
  localparam int RSP_OP_MSB   = 1;
  localparam int RSP_DATA_LSB = 2;
  localparam int RSP_DATA_MSB = 33;

  // Response returned to a DTM when the DM never answers: data 0, op failed.
  function automatic logic [RSP_DATA_MSB:0] dmi_fail_rsp();
    logic [RSP_DATA_MSB:0] r;
    r = '0;
    r[RSP_DATA_MSB:RSP_DATA_LSB] = '0;
    r[RSP_OP_MSB:RSP_OP_LSB] = DMI_OP_FAILED;
    return r;
  endfunction

endpackage

// File: rtl/dmi_rr_picker.sv
// Combinational round-robin selector: first asserted vld after index last (wrapping), zero latency.
// Produces a one-hot grant and its index; gnt is all-zero when no vld is set.
module dmi_rr_picker #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  vld,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] p;

  // Scan farthest candidate first so the nearest one after last overwrites it.
  always_comb begin
    gnt = '0;
    idx = '0;
    p   = '0;
    for (int k = N; k >= 1; k--) begin
      p = IW'((int'(last) + k) % N);
      if (vld[p]) begin
        gnt    = '0;
        gnt[p] = 1'b1;
        idx    = p;
      end
    end
  end

endmodule

// File: rtl/dmi_session_arbiter.sv
// Session-based arbiter sharing one DM DBus port among N_PORTS DTMs; one transaction in flight, 1-cycle hops.
// Optional DM response watchdog enabled by DMI_SESSION_RSP_TIMEOUT_EN.
module dmi_session_arbiter
  import dmi_pkg::*;
#(
  parameter int N_PORTS       = 2,
  parameter int DBUS_REQ_BITS = 41,
  parameter int DBUS_RSP_BITS = 34,
  parameter int IDLE_TIMEOUT  = 1024,
  parameter int RSP_TIMEOUT   = 4096
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_PORTS-1:0]                dtm_req_vld,
  output logic [N_PORTS-1:0]                dtm_req_rdy,
  input  logic [N_PORTS*DBUS_REQ_BITS-1:0]  dtm_req_bits,
  output logic [N_PORTS-1:0]                dtm_rsp_vld,
  input  logic [N_PORTS-1:0]                dtm_rsp_rdy,
  output logic [DBUS_RSP_BITS-1:0]          dtm_rsp_bits,
  output logic                              dm_req_vld,
  input  logic                              dm_req_rdy,
  output logic [DBUS_REQ_BITS-1:0]          dm_req_bits,
  input  logic                              dm_rsp_vld,
  output logic                              dm_rsp_rdy,
  input  logic [DBUS_RSP_BITS-1:0]          dm_rsp_bits,
  output logic                              session_vld,
  output logic [$clog2(N_PORTS)-1:0]        session_owner
);

  localparam int IW = $clog2(N_PORTS);
  localparam int CW = $clog2(IDLE_TIMEOUT);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_TIMEOUT - 1);

  state_t               state;
  logic [IW-1:0]        owner;
  logic [IW-1:0]        last_owner;
  logic [CW-1:0]        idle_cnt;
  logic [N_PORTS-1:0]   owner_1h;
  logic [N_PORTS-1:0]   pick_gnt;
  logic [IW-1:0]        pick_idx;
  logic [DBUS_REQ_BITS-1:0] req_slice [N_PORTS];

  for (genvar i = 0; i < N_PORTS; i++) begin : g_slice
    assign req_slice[i] = dtm_req_bits[i*DBUS_REQ_BITS +: DBUS_REQ_BITS];
  end

  dmi_rr_picker #(
    .N  (N_PORTS),
    .IW (IW)
  ) u_picker (
    .vld  (dtm_req_vld),
    .last (last_owner),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  assign owner_1h      = N_PORTS'(1) << owner;
  assign session_owner = owner;
  assign dm_req_vld    = (state == REQ);
  assign dtm_rsp_vld   = (state == DLV) ? owner_1h : '0;

  // Ready is forced low during reset even though the picker is purely combinational.
  always_comb begin
    dtm_req_rdy = '0;
    if (rst_n) begin
      if (state == IDLE)      dtm_req_rdy = pick_gnt;
      else if (state == HOLD) dtm_req_rdy = owner_1h;
    end
  end

`ifdef DMI_SESSION_RSP_TIMEOUT_EN
  localparam int WW = $clog2(RSP_TIMEOUT);
  localparam logic [WW-1:0] WD_LAST = WW'(RSP_TIMEOUT - 1);

  logic [WW-1:0] wd_cnt;
  logic          drain_pend;

  // After a watchdog expiry the port stays open for exactly one late DM response, which is dropped.
  assign dm_rsp_rdy = (state == RSP) || drain_pend;
`else
  logic unused_rsp_timeout;
  assign unused_rsp_timeout = ^RSP_TIMEOUT;
  assign dm_rsp_rdy = (state == RSP);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= '0;
      last_owner   <= IW'(N_PORTS - 1);
      idle_cnt     <= '0;
      session_vld  <= 1'b0;
      dm_req_bits  <= '0;
      dtm_rsp_bits <= '0;
`ifdef DMI_SESSION_RSP_TIMEOUT_EN
      wd_cnt       <= '0;
      drain_pend   <= 1'b0;
`endif
    end else begin
`ifdef DMI_SESSION_RSP_TIMEOUT_EN
      if (drain_pend && dm_rsp_vld && state != RSP) drain_pend <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|pick_gnt) begin
            dm_req_bits <= req_slice[pick_idx];
            owner       <= pick_idx;
            session_vld <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (dm_req_rdy) begin
            state <= RSP;
`ifdef DMI_SESSION_RSP_TIMEOUT_EN
            wd_cnt <= '0;
`endif
          end
        end
        RSP: begin
`ifdef DMI_SESSION_RSP_TIMEOUT_EN
          if (dm_rsp_vld && drain_pend) begin
            drain_pend <= 1'b0;
            wd_cnt     <= wd_cnt + 1'b1;
          end else if (dm_rsp_vld) begin
            dtm_rsp_bits <= dm_rsp_bits;
            state        <= DLV;
          end else if (wd_cnt == WD_LAST) begin
            dtm_rsp_bits <= DBUS_RSP_BITS'(dmi_fail_rsp());
            drain_pend   <= 1'b1;
            state        <= DLV;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`else
          if (dm_rsp_vld) begin
            dtm_rsp_bits <= dm_rsp_bits;
            state        <= DLV;
          end
`endif
        end
        DLV: begin
          if (dtm_rsp_rdy[owner]) begin
            idle_cnt <= '0;
            state    <= HOLD;
          end
        end
        HOLD: begin
          // An owner request on the expiry cycle keeps the session alive.
          if (dtm_req_vld[owner]) begin
            dm_req_bits <= req_slice[owner];
            state       <= REQ;
          end else if (idle_cnt == IDLE_LAST) begin
            session_vld <= 1'b0;
            last_owner  <= owner;
            state       <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
